// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation units and the writeback/flag stage:
// operation-class encodings, CVNZ bit masks and the per-class update mask.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_LOGIC   = 2'b00,
        OP_ARITH   = 2'b01,
        OP_COMPARE = 2'b10,
        OP_CLEAR   = 2'b11
    } op_class_e;

    // CCR bit positions, CVNZ order (shared with my_or and its siblings).
    localparam logic [3:0] C_MASK = 4'b1000;
    localparam logic [3:0] V_MASK = 4'b0100;
    localparam logic [3:0] N_MASK = 4'b0010;
    localparam logic [3:0] Z_MASK = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_DONE   = 2'b10
    } wb_state_e;

    // Which CCR bits a capture of the given class is allowed to overwrite.
    // Logic ops only own N and Z; everything else rewrites the whole CCR.
    function automatic logic [3:0] class_mask(op_class_e cls);
        logic [3:0] m;
        case (cls)
            OP_LOGIC: m = N_MASK | Z_MASK;
            default:  m = C_MASK | V_MASK | N_MASK | Z_MASK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_wb_latch_if.sv
// Bus between the ALU op units / sequencer (master) and the writeback stage (slave).
interface alu_wb_latch_if
    import alu_pkg::*;
#(
    parameter int op_size = 4
) ();

    logic               start;
    op_class_e          op_class;
    logic [op_size-1:0] r_in;
    logic [3:0]         ccr_in;
    logic [op_size-1:0] r_out;
    logic [3:0]         ccr_out;
    logic               busy;
    logic               done;
    logic               overrun;

    modport master (
        output start, op_class, r_in, ccr_in,
        input  r_out, ccr_out, busy, done, overrun
    );

    modport slave (
        input  start, op_class, r_in, ccr_in,
        output r_out, ccr_out, busy, done, overrun
    );

endinterface

// File: rtl/alu_wb_latch_settle_counter.sv
// Down-counter timing the settle window: loads a start value, counts down
// while enabled and reports when it has reached zero.
module settle_counter #(
    parameter int width = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] value,
    input  logic             en,
    output logic             zero
);

    logic [width-1:0] cnt_q;

    // Count register: load wins over decrement, and it never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_wb_latch.sv
// Writeback/flag-holding stage: waits a fixed settle window after start,
// then latches the op-unit result and merges its CCR into the persistent CCR.
module alu_wb_latch
    import alu_pkg::*;
#(
    parameter int op_size       = 4,
    parameter int settle_cycles = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_wb_latch_if.slave   bus
);

    localparam int cnt_w = $clog2(settle_cycles + 1);
    localparam logic [cnt_w-1:0] load_val = cnt_w'(settle_cycles - 1);

    wb_state_e          state_q;
    wb_state_e          state_d;
    op_class_e          cls_q;
    logic [op_size-1:0] r_q;
    logic [3:0]         ccr_q;
    logic               overrun_q;
    logic               busy;
    logic               done;
    logic               accept;
    logic               capture;
    logic               cnt_zero;
    logic [3:0]         mask;
    logic [3:0]         ccr_src;

    // A new request is accepted whenever no capture is in flight.
    assign accept  = bus.start && (state_q != ST_SETTLE);
    assign capture = (state_q == ST_SETTLE) && cnt_zero;

    settle_counter #(
        .width (cnt_w)
    ) u_settle_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .value (load_val),
        .en    (state_q == ST_SETTLE),
        .zero  (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_SETTLE: if (cnt_zero) state_d = ST_DONE;
            default:   state_d = bus.start ? ST_SETTLE : ST_IDLE;
        endcase
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SETTLE: busy = 1'b1;
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
    end

    // Clear-flags captures merge zeros through the full mask.
    assign mask    = class_mask(cls_q);
    assign ccr_src = (cls_q == OP_CLEAR) ? 4'b0000 : bus.ccr_in;

    // Class latch, result/CCR capture and the registered overrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q     <= OP_LOGIC;
            r_q       <= '0;
            ccr_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= bus.start && (state_q == ST_SETTLE);
            if (accept) cls_q <= bus.op_class;
            if (capture) begin
                ccr_q <= (ccr_q & ~mask) | (ccr_src & mask);
                if (cls_q == OP_LOGIC || cls_q == OP_ARITH) r_q <= bus.r_in;
            end
        end
    end

    assign bus.r_out   = r_q;
    assign bus.ccr_out = ccr_q;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_alu_wb_latch.sv
// Self-checking bench for alu_wb_latch: a window-level reference model predicts
// busy/done/overrun each cycle and pushes expected captures into a scoreboard
// that a separate monitor drains whenever the DUT pulses done.
module tb_alu_wb_latch;
    import alu_pkg::*;

    localparam int SETTLE = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_wb_latch_if #(.op_size(4)) bus ();

    alu_wb_latch #(
        .op_size       (4),
        .settle_cycles (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request accepted at edge e is captured at edge
    // e+SETTLE; requests seen while one is pending are rejected with overrun.
    bit          m_pending  = 0;
    int          m_edge     = 0;
    int          m_cap_edge = 0;
    op_class_e   m_cls      = OP_LOGIC;
    logic [3:0]  m_r        = '0;
    logic [3:0]  m_ccr      = '0;
    bit          e_busy     = 0;
    bit          e_done     = 0;
    bit          e_ovr      = 0;
    logic [7:0]  sb[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pending = 0;
            m_r       = '0;
            m_ccr     = '0;
            e_busy    = 0;
            e_done    = 0;
            e_ovr     = 0;
            sb.delete();
        end else begin
            bit was_busy;
            was_busy = m_pending;
            m_edge++;
            e_done = 0;
            e_ovr  = 0;
            if (m_pending && m_edge == m_cap_edge) begin
                case (m_cls)
                    OP_LOGIC:   begin m_r = bus.r_in; m_ccr = {m_ccr[3:2], bus.ccr_in[1:0]}; end
                    OP_ARITH:   begin m_r = bus.r_in; m_ccr = bus.ccr_in; end
                    OP_COMPARE: m_ccr = bus.ccr_in;
                    default:    m_ccr = 4'b0000;
                endcase
                sb.push_back({m_r, m_ccr});
                m_pending = 0;
                e_done    = 1;
            end
            if (bus.start) begin
                if (was_busy) begin
                    e_ovr = 1;
                end else begin
                    m_pending  = 1;
                    m_cap_edge = m_edge + SETTLE;
                    m_cls      = bus.op_class;
                end
            end
            e_busy = m_pending;
        end
    end

    // Monitor: compare status every cycle and drain the scoreboard on done.
    initial forever begin
        @(posedge clk);
        #2;
        if (rst_n) begin
            check("busy", bus.busy, e_busy);
            check("done", bus.done, e_done);
            check("overrun", bus.overrun, e_ovr);
            if (bus.done) begin
                check("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    logic [7:0] exp;
                    exp = sb.pop_front();
                    check("sb_r_out", bus.r_out, exp[7:4]);
                    check("sb_ccr_out", bus.ccr_out, exp[3:0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.op_class = op_class_e'($urandom_range(0, 3));
            bus.r_in     = 4'($urandom);
            bus.ccr_in   = 4'($urandom);
        end
    endtask

    // One request with data held until the capture; returns when done is visible.
    task automatic run_op(input op_class_e cls, input logic [3:0] r, input logic [3:0] c);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op_class = cls;
        bus.r_in     = r;
        bus.ccr_in   = c;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (SETTLE) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.op_class = OP_LOGIC;
        bus.r_in     = '0;
        bus.ccr_in   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_r_out", bus.r_out, 0);
        check("rst_ccr_out", bus.ccr_out, 0);
        rst_n = 1'b1;
        idle(2);

        // Logic op from reset.
        run_op(OP_LOGIC, 4'b1010, 4'b0010);
        check("t1_done", bus.done, 1);
        check("t1_r_out", bus.r_out, 4'b1010);
        check("t1_ccr_out", bus.ccr_out, 4'b0010);
        idle(2);

        // Logic op preserves C and V.
        run_op(OP_ARITH, 4'b0110, 4'b1100);
        check("t2_preset_ccr", bus.ccr_out, 4'b1100);
        idle(1);
        run_op(OP_LOGIC, 4'b0000, 4'b0001);
        check("t2_ccr_out", bus.ccr_out, 4'b1101);
        check("t2_r_out", bus.r_out, 4'b0000);
        idle(1);

        // Compare leaves the result alone.
        run_op(OP_ARITH, 4'b0011, 4'b0000);
        idle(1);
        run_op(OP_COMPARE, 4'b1111, 4'b1010);
        check("t3_r_out", bus.r_out, 4'b0011);
        check("t3_ccr_out", bus.ccr_out, 4'b1010);
        idle(2);

        // Second start one cycle later is rejected with overrun.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op_class = OP_ARITH;
        bus.r_in     = 4'b0101;
        bus.ccr_in   = 4'b0110;
        @(negedge clk);
        bus.op_class = OP_CLEAR;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4_overrun", bus.overrun, 1);
        repeat (2) @(negedge clk);
        check("t4_r_out", bus.r_out, 4'b0101);
        check("t4_ccr_out", bus.ccr_out, 4'b0110);
        idle(5);

        // start held high: back-to-back captures.
        repeat (14) begin
            @(negedge clk);
            bus.start    = 1'b1;
            bus.op_class = OP_ARITH;
            bus.r_in     = 4'($urandom);
            bus.ccr_in   = 4'($urandom);
        end
        idle(5);

        // Reset during SETTLE aborts the capture.
        run_op(OP_ARITH, 4'b1111, 4'b1111);
        idle(1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_class = OP_ARITH;
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_busy", bus.busy, 0);
        check("t6_ccr_out", bus.ccr_out, 0);
        check("t6_r_out", bus.r_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        // Randomized traffic.
        repeat (400) begin
            @(negedge clk);
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.op_class = op_class_e'($urandom_range(0, 3));
            bus.r_in     = 4'($urandom);
            bus.ccr_in   = 4'($urandom);
        end
        idle(8);
        check("sb_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
